multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the RV32I-subset datapath across multiple cycles, replacing the single-cycle combinational control.
- Sequence: fetch, decode, execute, memory, writeback.
- Sits beside the datapath. Consumes the decoded opcode, the ALU zero flag and a memory-ready handshake.
- Drives all datapath enables and mux selects, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  7  instruction[6:0], taken from the instruction register
- aluZero  input  1  ALU zero flag
- memReady  input  1  memory access completes in the current cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if aluZero (beq)
- pcSource  output  1  0 = ALU result (PC+4), 1 = ALUOut register (branch target)
- irWrite  output  1  instruction register load
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- memtoReg  output  1  writeback select: 1 = memory data register, 0 = ALUOut
- regwrite  output  1  register file write enable
- aluSrcA  output  1  0 = PC, 1 = rs1 data
- aluSrcB  output  2  0 = rs2 data, 1 = constant 4, 2 = immediate
- aluOp  output  2  0 = add, 1 = sub (branch compare), 2 = use funct fields
- halted  output  1  sticky illegal-opcode flag
- state  output  4  current state encoding (debug)
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset: state=IDLE(0), instret=0, halted=0. While reset is high and in IDLE, every control output is 0.
- Outputs are decoded combinationally from the state register only. Exception: pcWrite and irWrite in FETCH are gated by memReady.
- Output value rules:
  - Any output not listed for a state is 0.
  - aluSrcB and aluOp default to 0 when not listed.
- States and outputs:
  - IDLE(0): no outputs asserted. Next: FETCH.
  - FETCH(1): memRead=1, iorD=0, aluSrcA=0, aluSrcB=1, aluOp=0; irWrite=pcWrite=memReady. Stays in FETCH while memReady=0; DECODE when memReady=1.
  - DECODE(2): aluSrcA=0, aluSrcB=2, aluOp=0 (precomputes the branch target into ALUOut). Next, by opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADDR
    - 0110011 (R-type) -> EXEC_R
    - 0010011 (I-type ALU) -> EXEC_I
    - 1100011 (beq) -> BRANCH
    - any other opcode -> HALT
  - MEMADDR(3): aluSrcA=1, aluSrcB=2, aluOp=0. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD(4): memRead=1, iorD=1. Stays while memReady=0; then MEMWB.
  - MEMWB(5): regwrite=1, memtoReg=1. Next: FETCH, instret += 1.
  - MEMWRITE(6): memWrite=1, iorD=1. Stays while memReady=0; then FETCH, instret += 1.
  - EXEC_R(7): aluSrcA=1, aluSrcB=0, aluOp=2. Next: ALUWB.
  - EXEC_I(8): aluSrcA=1, aluSrcB=2, aluOp=2. Next: ALUWB.
  - ALUWB(9): regwrite=1, memtoReg=0. Next: FETCH, instret += 1.
  - BRANCH(10): aluSrcA=1, aluSrcB=0, aluOp=1, pcWriteCond=1, pcSource=1. Next: FETCH, instret += 1.
  - HALT(11): halted=1, all other outputs 0. Remains in HALT until reset.
- Undefined encodings 12-15 go to IDLE on the next cycle.
- Cycle counts with memReady=1 throughout:
  - lw: 5 cycles; sw: 4; R-type and I-type: 4; beq: 3 (excluding the single IDLE cycle after reset).
- Each memReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- memRead/memWrite stay asserted and stable for the whole wait.
- instret wraps modulo 2^CNT_W and does not saturate.
- opcode is sampled only in DECODE and MEMADDR; changes in other states are ignored.
- Reset asserted in any state, including mid-wait and HALT: the next state is IDLE and instret=0. Any pending memory request is dropped (memRead=memWrite=0 from the following cycle).

Test Plan:
- Reset then R-type (0110011), memReady=1 -> states 0,1,2,7,9,1; regwrite=1 only in ALUWB; instret=1 after 5 clocks from reset release.
- lw (0000011) with memReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles with memRead=1, iorD=1; then MEMWB with regwrite=1, memtoReg=1; instret +1.
- sw (0100011) -> MEMWRITE with memWrite=1; regwrite never asserted; FETCH after memReady=1; instret +1.
- beq (1100011) with aluZero=1, then with aluZero=0 -> BRANCH shows pcWriteCond=1, pcSource=1, aluOp=1 in both cases; 3 cycles per instruction.
- Illegal opcode 1111111 -> HALT, halted=1 and held over 10 cycles; instret unchanged; reset -> IDLE, halted=0.
- CNT_W=4: retire 17 instructions -> instret=1 (wrap). Reset asserted during a FETCH wait -> IDLE, memRead=0 the next cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle sequencing FSM for the RV32I-subset datapath: walks fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects from the state register, and counts retired instructions.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | post-reset bubble, no outputs
// FETCH    | read instruction at PC, PC+4 into PC/IR when memReady
// DECODE   | branch target precomputed into ALUOut, dispatch on opcode
// MEMADDR  | effective address rs1 + imm
// MEMREAD  | load request held until memReady
// MEMWB    | load data written to rd
// MEMWRITE | store request held until memReady
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// ALUWB    | ALU result written to rd
// BRANCH   | compare rs1/rs2, PC <= ALUOut if equal
// HALT     | illegal opcode seen, parked until reset
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             aluZero,
   input  logic             memReady,
   output logic             pcWrite,
   output logic             pcWriteCond,
   output logic             pcSource,
   output logic             irWrite,
   output logic             memRead,
   output logic             memWrite,
   output logic             iorD,
   output logic             memtoReg,
   output logic             regwrite,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       aluOp,
   output logic             halted,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADDR  = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXEC_R   = 4'd7,
      S_EXEC_I   = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   localparam logic [6:0]       OP_LW  = 7'b0000011;
   localparam logic [6:0]       OP_SW  = 7'b0100011;
   localparam logic [6:0]       OP_R   = 7'b0110011;
   localparam logic [6:0]       OP_I   = 7'b0010011;
   localparam logic [6:0]       OP_BEQ = 7'b1100011;
   localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t state_q;

   // The branch decision (pcWriteCond & aluZero) is formed in the datapath's PC-enable logic.
   logic unused_alu_zero;
   assign unused_alu_zero = aluZero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         instret <= '0;
      end else begin
         case (state_q)
            S_IDLE:   state_q <= S_FETCH;
            S_FETCH:  if (memReady) state_q <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: state_q <= S_MEMADDR;
                  OP_R:         state_q <= S_EXEC_R;
                  OP_I:         state_q <= S_EXEC_I;
                  OP_BEQ:       state_q <= S_BRANCH;
                  default:      state_q <= S_HALT;
               endcase
            end
            S_MEMADDR: begin
               if (opcode == OP_LW)
                  state_q <= S_MEMREAD;
               else if (opcode == OP_SW)
                  state_q <= S_MEMWRITE;
               else
                  state_q <= S_HALT;
            end
            S_MEMREAD: if (memReady) state_q <= S_MEMWB;
            S_MEMWB: begin
               state_q <= S_FETCH;
               instret <= instret + ONE;
            end
            S_MEMWRITE: begin
               if (memReady) begin
                  state_q <= S_FETCH;
                  instret <= instret + ONE;
               end
            end
            S_EXEC_R: state_q <= S_ALUWB;
            S_EXEC_I: state_q <= S_ALUWB;
            S_ALUWB, S_BRANCH: begin
               state_q <= S_FETCH;
               instret <= instret + ONE;
            end
            S_HALT:   state_q <= S_HALT;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      pcSource    = 1'b0;
      irWrite     = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      iorD        = 1'b0;
      memtoReg    = 1'b0;
      regwrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'd0;
      aluOp       = 2'd0;
      halted      = 1'b0;
      case (state_q)
         S_FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'd1;
            irWrite = memReady;
            pcWrite = memReady;
         end
         S_DECODE:  aluSrcB = 2'd2;
         S_MEMADDR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'd2;
         end
         S_MEMREAD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoReg = 1'b1;
         end
         S_MEMWRITE: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
         end
         S_EXEC_R: begin
            aluSrcA = 1'b1;
            aluOp   = 2'd2;
         end
         S_EXEC_I: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'd2;
            aluOp   = 2'd2;
         end
         S_ALUWB:  regwrite = 1'b1;
         S_BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = 2'd1;
            pcWriteCond = 1'b1;
            pcSource    = 1'b1;
         end
         S_HALT:   halted = 1'b1;
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its state sequence
// with hand-written expected states and control vectors, plus halt, counter wrap and mid-wait reset.
module tb_multicycle_control;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [6:0]       opcode;
   logic             aluZero;
   logic             memReady;
   logic             pcWrite, pcWriteCond, pcSource, irWrite, memRead, memWrite;
   logic             iorD, memtoReg, regwrite, aluSrcA, halted;
   logic [1:0]       aluSrcB, aluOp;
   logic [3:0]       state;
   logic [CNT_W-1:0] instret;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .aluZero(aluZero), .memReady(memReady),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource), .irWrite(irWrite),
      .memRead(memRead), .memWrite(memWrite), .iorD(iorD), .memtoReg(memtoReg),
      .regwrite(regwrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
      .halted(halted), .state(state), .instret(instret)
   );

   // {pcWrite, pcWriteCond, pcSource, irWrite, memRead, memWrite, iorD, memtoReg, regwrite, aluSrcA, aluSrcB, aluOp, halted}
   logic [14:0] ctl;
   assign ctl = {pcWrite, pcWriteCond, pcSource, irWrite, memRead, memWrite, iorD, memtoReg,
                 regwrite, aluSrcA, aluSrcB, aluOp, halted};

   localparam logic [14:0] C_IDLE    = 15'd0;
   localparam logic [14:0] C_FETCH   = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,1'b0};
   localparam logic [14:0] C_FWAIT   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,1'b0};
   localparam logic [14:0] C_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,1'b0};
   localparam logic [14:0] C_MEMADDR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0};
   localparam logic [14:0] C_MEMRD   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0};
   localparam logic [14:0] C_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,1'b0};
   localparam logic [14:0] C_MEMWR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0};
   localparam logic [14:0] C_EXECR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd2,1'b0};
   localparam logic [14:0] C_EXECI   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd2,1'b0};
   localparam logic [14:0] C_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0};
   localparam logic [14:0] C_BRANCH  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b0};
   localparam logic [14:0] C_HALT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1};

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = 7'd0; aluZero = 1'b0; memReady = 1'b0;
      tick(); tick();
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE); end
      checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
      reset = 1'b0;
   endtask

   task automatic test_rtype();
      logic [3:0]  es [6];
      logic [14:0] ec [6];
      es = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd9, 4'd1};
      ec = '{C_IDLE, C_FETCH, C_DECODE, C_EXECR, C_ALUWB, C_FETCH};
      opcode = OP_R; memReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) opcode = OP_BAD;  // must be ignored outside DECODE/MEMADDR
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL rtype_ctl[%0d]: got %b expected %b", i, ctl, ec[i]); end
         if (i == 4) begin
            checks++; if (instret !== 4'd0) begin errors++; $display("FAIL rtype_instret_pre: got %0d expected 0", instret); end
         end
         if (i < 5) tick();
      end
      checks++; if (instret !== 4'd1) begin errors++; $display("FAIL rtype_instret: got %0d expected 1", instret); end
   endtask

   task automatic test_lw();
      logic [3:0]  es [10];
      logic [14:0] ec [10];
      logic        rd [10];
      es = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
      ec = '{C_FWAIT, C_FETCH, C_DECODE, C_MEMADDR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_FETCH};
      rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      opcode = OP_LW;
      for (int i = 0; i < 10; i++) begin
         memReady = rd[i];
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL lw_ctl[%0d]: got %b expected %b", i, ctl, ec[i]); end
         if (i < 9) tick();
      end
      checks++; if (instret !== 4'd2) begin errors++; $display("FAIL lw_instret: got %0d expected 2", instret); end
   endtask

   task automatic test_sw();
      logic [3:0]  es [6];
      logic [14:0] ec [6];
      logic        rd [6];
      es = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd1};
      ec = '{C_FETCH, C_DECODE, C_MEMADDR, C_MEMWR, C_MEMWR, C_FETCH};
      rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      opcode = OP_SW;
      for (int i = 0; i < 6; i++) begin
         memReady = rd[i];
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL sw_ctl[%0d]: got %b expected %b", i, ctl, ec[i]); end
         if (i < 5) tick();
      end
      checks++; if (instret !== 4'd3) begin errors++; $display("FAIL sw_instret: got %0d expected 3", instret); end
   endtask

   task automatic test_itype();
      logic [3:0]  es [5];
      logic [14:0] ec [5];
      es = '{4'd1, 4'd2, 4'd8, 4'd9, 4'd1};
      ec = '{C_FETCH, C_DECODE, C_EXECI, C_ALUWB, C_FETCH};
      opcode = OP_I; memReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL itype_state[%0d]: got %0d expected %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL itype_ctl[%0d]: got %b expected %b", i, ctl, ec[i]); end
         if (i < 4) tick();
      end
      checks++; if (instret !== 4'd4) begin errors++; $display("FAIL itype_instret: got %0d expected 4", instret); end
   endtask

   task automatic test_beq();
      logic [3:0]  es [4];
      logic [14:0] ec [4];
      logic [3:0]  exp_cnt;
      es = '{4'd1, 4'd2, 4'd10, 4'd1};
      ec = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH};
      opcode = OP_BEQ; memReady = 1'b1;
      for (int z = 0; z < 2; z++) begin
         aluZero = (z == 0);
         exp_cnt = 4'd5 + 4'(z);
         for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== es[i]) begin errors++; $display("FAIL beq%0d_state[%0d]: got %0d expected %0d", z, i, state, es[i]); end
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL beq%0d_ctl[%0d]: got %b expected %b", z, i, ctl, ec[i]); end
            if (i < 3) tick();
         end
         checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL beq%0d_instret: got %0d expected %0d", z, instret, exp_cnt); end
      end
      aluZero = 1'b0;
   endtask

   task automatic test_halt();
      opcode = OP_BAD; memReady = 1'b1;
      tick(); tick();
      #1;
      checks++; if (state !== 4'd11) begin errors++; $display("FAIL halt_enter: got %0d expected 11", state); end
      opcode = OP_R;
      for (int i = 0; i < 10; i++) begin
         tick();
         #1;
         checks++; if (state !== 4'd11 || ctl !== C_HALT) begin
            errors++; $display("FAIL halt_hold[%0d]: got state %0d ctl %b expected 11 %b", i, state, ctl, C_HALT);
         end
      end
      checks++; if (instret !== 4'd6) begin errors++; $display("FAIL halt_instret: got %0d expected 6", instret); end
      reset = 1'b1;
      tick();
      #1;
      checks++; if (state !== 4'd0 || halted !== 1'b0) begin
         errors++; $display("FAIL halt_reset: got state %0d halted %0b expected 0 0", state, halted);
      end
      checks++; if (instret !== 4'd0) begin errors++; $display("FAIL halt_reset_instret: got %0d expected 0", instret); end
      reset = 1'b0;
   endtask

   task automatic test_wrap();
      opcode = OP_R; memReady = 1'b1;
      tick();
      for (int n = 0; n < 17; n++) begin
         repeat (4) tick();
         if (n == 15) begin
            #1;
            checks++; if (instret !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d expected 0", instret); end
         end
      end
      #1;
      checks++; if (instret !== 4'd1) begin errors++; $display("FAIL wrap_17: got %0d expected 1", instret); end
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL wrap_state: got %0d expected 1", state); end
   endtask

   task automatic test_reset_midwait();
      memReady = 1'b0;
      #1;
      checks++; if (ctl !== C_FWAIT) begin errors++; $display("FAIL fwait_ctl: got %b expected %b", ctl, C_FWAIT); end
      reset = 1'b1;
      tick();
      #1;
      checks++; if (state !== 4'd0 || memRead !== 1'b0) begin
         errors++; $display("FAIL fwait_reset: got state %0d memRead %0b expected 0 0", state, memRead);
      end
      checks++; if (instret !== 4'd0) begin errors++; $display("FAIL fwait_reset_instret: got %0d expected 0", instret); end
      reset = 1'b0; opcode = OP_SW; memReady = 1'b1;
      repeat (4) tick();
      memReady = 1'b0;
      tick();
      #1;
      checks++; if (state !== 4'd6 || memWrite !== 1'b1) begin
         errors++; $display("FAIL swait_state: got state %0d memWrite %0b expected 6 1", state, memWrite);
      end
      reset = 1'b1;
      tick();
      #1;
      checks++; if (state !== 4'd0 || memWrite !== 1'b0) begin
         errors++; $display("FAIL swait_reset: got state %0d memWrite %0b expected 0 0", state, memWrite);
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw();
      test_sw();
      test_itype();
      test_beq();
      test_halt();
      test_wrap();
      test_reset_midwait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
